// File: rtl/iomem_bus_ctrl.sv
// iomem peripheral bus sequencer: latches each CPU access, routes it to the slave whose ID matches addr[31:24].
// Define IOMEM_TIMEOUT_EN to build the slave-timeout timer; without it ACCESS waits for s_ready forever.

module iomem_bus_ctrl #(
  parameter int                    N_SLAVES  = 4,
  parameter logic [8*N_SLAVES-1:0] SLAVE_IDS = {8'h07, 8'h05, 8'h04, 8'h03},
  parameter int                    TIMEOUT   = 255,
  parameter logic [31:0]           ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic [N_SLAVES-1:0]      s_valid,
  input  logic [N_SLAVES-1:0]      s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  output logic                     err,
  output logic [31:0]              err_addr
);

  typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  m_ready_q, m_ready_d;
  logic [31:0]           m_rdata_q, m_rdata_d;
  logic [N_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic [3:0]            s_wstrb_q, s_wstrb_d;
  logic [31:0]           s_addr_q, s_addr_d;
  logic [31:0]           s_wdata_q, s_wdata_d;
  logic                  err_q, err_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [N_SLAVES-1:0]   hit_vec;
  logic                  hit;
  logic                  ready_sel;
  logic [31:0]           sel_rdata;
  logic                  expire;

  // First matching slot wins, so duplicated IDs resolve to the lowest index.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit && (s_addr_q[31:24] == SLAVE_IDS[8*i +: 8])) begin
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_valid_q[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
    end
  end

  assign ready_sel = |(s_ready & s_valid_q);

`ifdef IOMEM_TIMEOUT_EN
  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign expire = (state_q == ACCESS) && (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = timer_q;
    if (state_q == DECODE) begin
      timer_d = '0;
    end else if ((state_q == ACCESS) && !ready_sel && !expire) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign expire = 1'b0;

  // TIMEOUT has no effect in this build.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_valid) state_d = DECODE;
      DECODE:  state_d = hit ? ACCESS : RESP;
      ACCESS:  if (ready_sel || expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: the values below appear on the pins after the next edge.
  always_comb begin
    m_ready_d  = 1'b0;
    m_rdata_d  = m_rdata_q;
    s_valid_d  = s_valid_q;
    s_wstrb_d  = s_wstrb_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
        end
      end
      DECODE: begin
        if (hit) begin
          s_valid_d = hit_vec;
        end else begin
          m_ready_d  = 1'b1;
          m_rdata_d  = ERR_RDATA;
          err_d      = 1'b1;
          err_addr_d = s_addr_q;
        end
      end
      ACCESS: begin
        if (ready_sel) begin
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_rdata_d = sel_rdata;
        end else if (expire) begin
          s_valid_d  = '0;
          m_ready_d  = 1'b1;
          m_rdata_d  = ERR_RDATA;
          err_d      = 1'b1;
          err_addr_d = s_addr_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_ready_q  <= 1'b0;
      m_rdata_q  <= '0;
      s_valid_q  <= '0;
      s_wstrb_q  <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
      s_valid_q  <= s_valid_d;
      s_wstrb_q  <= s_wstrb_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_ready  = m_ready_q;
  assign m_rdata  = m_rdata_q;
  assign s_valid  = s_valid_q;
  assign s_wstrb  = s_wstrb_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
